// File: rtl/configuration_regbank_pkg.sv
// cfg_pkg: shared definitions for the configuration register bank.
//   - unlock FSM state encoding (LOCKED/ARMED/OPEN)
//   - default unlock keys
//   - even-parity helper used when CFG_PARITY_EN is defined
package cfg_pkg;

  localparam logic [1:0] LOCKED = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] OPEN   = 2'd2;

  typedef enum logic [1:0] {
    ST_LOCKED = LOCKED,
    ST_ARMED  = ARMED,
    ST_OPEN   = OPEN
  } state_e;

  localparam logic [7:0] KEY0_DEF = 8'hAA;
  localparam logic [7:0] KEY1_DEF = 8'h55;

  // Parity helper takes a zero-extended word; zero padding does not change
  // the XOR reduction, so any register width up to PAR_MAXW is covered.
  localparam int PAR_MAXW = 64;

  // Even-parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/configuration_regbank_unlock_fsm.sv
// cfg_unlock_fsm: key-sequence unlock detector plus bounded write window.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   wstb     in   write strobe
//   dbus     in   write data / key value
//   addr_ok  in   current address is inside the implemented register range
//   wr_ok    out  bank writable this cycle (state is OPEN)
//   unlocked out  registered, high while the FSM is in OPEN
//   seq_err  out  registered one-cycle pulse on a bad key or bad address
module cfg_unlock_fsm
  import cfg_pkg::*;
#(
  parameter int            DW   = 8,
  parameter logic [DW-1:0] KEY0 = KEY0_DEF,
  parameter logic [DW-1:0] KEY1 = KEY1_DEF,
  parameter int            WIN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wstb,
  input  logic [DW-1:0] dbus,
  input  logic          addr_ok,
  output logic          wr_ok,
  output logic          unlocked,
  output logic          seq_err
);

  localparam int CW = $clog2(WIN + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
  logic          unl_q, serr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOCKED;
      cnt_q   <= '0;
      unl_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unl_q   <= (state_d == ST_OPEN);
      serr_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_LOCKED: begin
        if (wstb && dbus == KEY0) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (wstb) begin
          if (dbus == KEY1) begin
            state_d = ST_OPEN;
            cnt_d   = CW'(WIN);
          end else if (dbus != KEY0) begin
            // KEY0 again simply restarts the sequence; anything else aborts
            state_d = ST_LOCKED;
            err_d   = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        cnt_d = cnt_q - CW'(1);
        if (wstb && !addr_ok) err_d = 1'b1;
        // The edge seeing cnt==1 is still a write edge; it closes the window
        if (cnt_q == CW'(1)) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_LOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_ok    = (state_q == ST_OPEN);
  assign unlocked = unl_q;
  assign seq_err  = serr_q;

endmodule

// File: rtl/configuration_regbank.sv
// configuration_regbank: key-protected NREG x DW configuration register bank.
// Unlock with KEY0 then KEY1; the bank then accepts WIN write edges.
// Optional macro CFG_PARITY_EN adds per-register even parity and a sticky PERR.
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous active-low reset
//   WSTB     in   write strobe; ABUS/DBUS only sampled when high
//   ABUS     in   write address
//   DBUS     in   write data / key value
//   RADDR    in   readback address
//   RDATA    out  registered reg[RADDR], 0 for RADDR>=NREG
//   REGS     out  flat live register contents, reg i = [i*DW +: DW]
//   UNLOCKED out  high while the window is open
//   SEQERR   out  one-cycle pulse after a sequence or address error
//   PERR     out  sticky parity error (0 unless CFG_PARITY_EN)
module configuration_regbank
  import cfg_pkg::*;
#(
  parameter int                 DW      = 8,
  parameter int                 AW      = 2,
  parameter int                 NREG    = 4,
  parameter logic [DW-1:0]      KEY0    = KEY0_DEF,
  parameter logic [DW-1:0]      KEY1    = KEY1_DEF,
  parameter int                 WIN     = 4,
  parameter logic [NREG*DW-1:0] RST_VAL = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WSTB,
  input  logic [AW-1:0]      ABUS,
  input  logic [DW-1:0]      DBUS,
  input  logic [AW-1:0]      RADDR,
  output logic [DW-1:0]      RDATA,
  output logic [NREG*DW-1:0] REGS,
  output logic               UNLOCKED,
  output logic               SEQERR,
  output logic               PERR
);

  localparam logic [AW:0] NREG_A = (AW + 1)'(NREG);

  logic [NREG-1:0][DW-1:0] regs_q;
  logic [DW-1:0]           rd_mux;
  logic [DW-1:0]           rdata_q;
  logic                    addr_ok, wr_ok, wr_en;

  assign addr_ok = ({1'b0, ABUS} < NREG_A);

  cfg_unlock_fsm #(
    .DW   (DW),
    .KEY0 (KEY0),
    .KEY1 (KEY1),
    .WIN  (WIN)
  ) u_fsm (
    .clk      (CLK),
    .rst      (RST),
    .wstb     (WSTB),
    .dbus     (DBUS),
    .addr_ok  (addr_ok),
    .wr_ok    (wr_ok),
    .unlocked (UNLOCKED),
    .seq_err  (SEQERR)
  );

  assign wr_en = WSTB && wr_ok && addr_ok;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREG; i++) begin
      if (!RST)                            regs_q[i] <= RST_VAL[i*DW +: DW];
      else if (wr_en && ABUS == AW'(i))    regs_q[i] <= DBUS;
    end
  end

  // Explicit compare loop keeps the mux in range when NREG < 2**AW
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREG; i++)
      if (RADDR == AW'(i)) rd_mux = regs_q[i];
  end

  // Reads the pre-write value when a write hits the same address this edge
  always_ff @(posedge CLK) begin
    if (!RST) rdata_q <= '0;
    else      rdata_q <= rd_mux;
  end

  assign RDATA = rdata_q;
  assign REGS  = regs_q;

`ifdef CFG_PARITY_EN
  logic [NREG-1:0] par_q;
  logic [NREG-1:0] par_bad;
  logic            perr_q;

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < NREG; i++)
      par_bad[i] = par_q[i] ^ even_par(PAR_MAXW'(regs_q[i]));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++)
        par_q[i] <= even_par(PAR_MAXW'(RST_VAL[i*DW +: DW]));
      perr_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wr_en && ABUS == AW'(i)) par_q[i] <= even_par(PAR_MAXW'(DBUS));
      perr_q <= perr_q | (|par_bad);
    end
  end

  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule
